// File: rtl/base_system_nios2_gen2_0_cpu_mult_combine_if.sv
// Bus between the multiplier cell / issue logic and the product combiner:
// partial products, the request handshake with its tag, flush, and the result handshake.
interface base_system_nios2_gen2_0_cpu_mult_combine_if #(
    parameter int TAG_W = 5
);
    logic [31:0]      M_mul_cell_p1;
    logic [31:0]      M_mul_cell_p2;
    logic [31:0]      M_mul_cell_p3;
    logic             in_valid;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_ready;

    modport master (
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output in_valid, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  in_valid, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/base_system_nios2_gen2_0_cpu_mult_combine.sv
// Combines three 16x16 partial products into the low 32 bits of a 32x32 product
// through a two-stage valid/ready pipeline that carries the destination tag and honours flush.
module base_system_nios2_gen2_0_cpu_mult_combine #(
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic reset,
    base_system_nios2_gen2_0_cpu_mult_combine_if.slave bus
);

    // Only the low halves of the cross products reach bits [31:16] of the result.
    function automatic logic [15:0] cross_sum(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    logic             s1_v_r;
    logic [31:0]      s1_lo_r;
    logic [15:0]      s1_cross_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic             s2_v_r;
    logic [31:0]      s2_res_r;
    logic [TAG_W-1:0] s2_tag_r;

    logic s2_adv_s;
    logic s1_adv_s;
    logic unused_hi_s;

    assign unused_hi_s = ^{bus.M_mul_cell_p2[31:16], bus.M_mul_cell_p3[31:16]};

    // Advance terms: the only combinational path is out_ready -> in_ready.
    always_comb begin
        s2_adv_s = !s2_v_r || bus.out_ready;
        s1_adv_s = !s1_v_r || s2_adv_s;
    end

    // Stage 1: capture the low product and the folded cross term.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_r     <= 1'b0;
            s1_lo_r    <= 32'h0000_0000;
            s1_cross_r <= 16'h0000;
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (bus.flush) begin
            s1_v_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_v_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_lo_r    <= bus.M_mul_cell_p1;
                s1_cross_r <= cross_sum(bus.M_mul_cell_p2[15:0], bus.M_mul_cell_p3[15:0]);
                s1_tag_r   <= bus.in_tag;
            end else begin
                s1_lo_r <= s1_lo_r;
            end
        end else begin
            s1_v_r <= s1_v_r;
        end
    end

    // Stage 2: final add; holds while the consumer stalls a valid result.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v_r   <= 1'b0;
            s2_res_r <= 32'h0000_0000;
            s2_tag_r <= {TAG_W{1'b0}};
        end else if (bus.flush) begin
            s2_v_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_v_r   <= s1_v_r;
            s2_res_r <= s1_lo_r + {s1_cross_r, 16'h0000};
            s2_tag_r <= s1_tag_r;
        end else begin
            s2_v_r <= s2_v_r;
        end
    end

    assign bus.in_ready   = s1_adv_s;
    assign bus.out_valid  = s2_v_r;
    assign bus.out_result = s2_res_r;
    assign bus.out_tag    = s2_tag_r;

endmodule

// File: tb/tb_base_system_nios2_gen2_0_cpu_mult_combine.sv
// Directed bench for the product combiner: arithmetic vectors, latency,
// backpressure ordering, flush and mid-stream reset.
module tb_base_system_nios2_gen2_0_cpu_mult_combine;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    base_system_nios2_gen2_0_cpu_mult_combine_if #(.TAG_W(5)) bus ();

    base_system_nios2_gen2_0_cpu_mult_combine #(.TAG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] p1, input logic [31:0] p2,
                            input logic [31:0] p3, input logic [4:0] tag);
        bus.M_mul_cell_p1 = p1;
        bus.M_mul_cell_p2 = p2;
        bus.M_mul_cell_p3 = p3;
        bus.in_tag        = tag;
        bus.in_valid      = 1'b1;
    endtask

    // Single op through an empty pipe with out_ready high.
    task automatic send_one(input string name, input logic [31:0] p1, input logic [31:0] p2,
                            input logic [31:0] p3, input logic [4:0] tag, input logic [31:0] exp);
        bus.out_ready = 1'b1;
        drive_op(p1, p2, p3, tag);
        #1;
        check_val({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check_val({name, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        step();
        check_val({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({name, "_result"}, bus.out_result, exp);
        check_val({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        step();
        check_val({name, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [4:0] next_tag;
        int         rx_count;
        logic       fire_in;
        logic       fire_out;

        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_tag        = 5'd0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        bus.M_mul_cell_p1 = 32'h0;
        bus.M_mul_cell_p2 = 32'h0;
        bus.M_mul_cell_p3 = 32'h0;
        step();
        step();
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_result", bus.out_result, 32'h0);
        check_val("rst_tag", 32'(bus.out_tag), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send_one("basic", 32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 5'd3, 32'h0016_0008);
        send_one("wrap", 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd12, 32'h0000_0001);
        send_one("signed", 32'h0002_FFFA, 32'h0000_0000, 32'h0002_FFFD, 5'd21, 32'hFFFF_FFFA);
        send_one("crossc", 32'h1234_5678, 32'hABCD_8000, 32'h0000_8001, 5'd31, 32'h1235_5678);

        // Backpressure: tag t yields result {t, t} (upper halves of p2/p3 are junk).
        bus.out_ready = 1'b1;
        drive_op(32'd1, 32'hDEAD_0001, 32'hBEEF_0000, 5'd1);
        step();
        next_tag = 5'd2;
        rx_count = 0;
        for (int cyc = 0; cyc < 20 && rx_count < 4; cyc++) begin
            bus.out_ready = (cyc >= 4);
            if (next_tag <= 5'd4) drive_op(32'(next_tag), 32'hDEAD_0000 | 32'(next_tag), 32'hBEEF_0000, next_tag);
            else bus.in_valid = 1'b0;
            #1;
            if (cyc >= 1 && cyc <= 3) begin
                check_val("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check_val("bp_hold_tag", 32'(bus.out_tag), 32'd1);
                check_val("bp_hold_result", bus.out_result, 32'h0001_0001);
            end
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                check_val("bp_order_tag", 32'(bus.out_tag), 32'(rx_count + 1));
                check_val("bp_order_result", bus.out_result, {16'(rx_count + 1), 16'(rx_count + 1)});
                rx_count++;
            end
            step();
            if (fire_in) next_tag = next_tag + 5'd1;
        end
        bus.in_valid = 1'b0;
        check_val("bp_count", 32'(rx_count), 32'd4);
        check_val("bp_empty", 32'(bus.out_valid), 32'd0);

        // Flush with both stages full and a new op offered while in_ready is high.
        bus.out_ready = 1'b0;
        drive_op(32'h5, 32'h0, 32'h0, 5'd5);
        step();
        drive_op(32'h6, 32'h0, 32'h0, 5'd6);
        step();
        check_val("fl_full", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        drive_op(32'h7, 32'h0, 32'h0, 5'd7);
        #1;
        check_val("fl_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("fl_valid0", 32'(bus.out_valid), 32'd0);
        step();
        check_val("fl_no_tag7", 32'(bus.out_valid), 32'd0);
        send_one("post_flush", 32'h0000_0100, 32'h0000_0002, 32'h0000_0003, 5'd8, 32'h0005_0100);

        // Reset while both stages hold valid results.
        bus.out_ready = 1'b0;
        drive_op(32'h9, 32'h0, 32'h0, 5'd9);
        step();
        drive_op(32'hA, 32'h0, 32'h0, 5'd10);
        step();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("mr_valid", 32'(bus.out_valid), 32'd0);
        check_val("mr_result", bus.out_result, 32'h0);
        check_val("mr_tag", 32'(bus.out_tag), 32'd0);
        check_val("mr_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check_val("mr_stale1", 32'(bus.out_valid), 32'd0);
        step();
        check_val("mr_stale2", 32'(bus.out_valid), 32'd0);
        send_one("post_reset", 32'h0000_0011, 32'h0000_0001, 32'h0000_0001, 5'd17, 32'h0002_0011);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
